// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache and D-cache requests onto one pipelined memory.
// Fills are issued as BURST back-to-back reads from the aligned block base, and the
// returned words are steered to the granted cache. D-cache writes are single-word.
module mem_arbiter #(
   parameter int BURST  = 8,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_req,
   input  logic [ADDR_W-1:0]        i_addr,
   output logic                     i_busy,
   output logic                     i_data_valid,
   output logic [$clog2(BURST)-1:0] i_word,
   output logic                     i_done,
   input  logic                     d_req,
   input  logic                     d_wr,
   input  logic [ADDR_W-1:0]        d_addr,
   input  logic [DATA_W-1:0]        d_wdata,
   output logic                     d_busy,
   output logic                     d_data_valid,
   output logic [$clog2(BURST)-1:0] d_word,
   output logic                     d_done,
   output logic [DATA_W-1:0]        rd_data,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic                     mem_enable,
   output logic                     mem_wr,
   output logic [DATA_W-1:0]        mem_data_in,
   input  logic [DATA_W-1:0]        mem_data_out,
   input  logic                     mem_data_valid
);

   localparam int CW = $clog2(BURST);
   localparam logic [CW-1:0] LAST = CW'(BURST - 1);
   // Block alignment mask: BURST words of 2 bytes each.
   localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * BURST - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_t;

   state_t            state;
   logic              grant_d;    // current owner: 1 = D-cache, 0 = I-cache
   logic              last_d;     // owner of the most recent grant
   logic [ADDR_W-1:0] addr_reg;   // address latched at grant
   logic [DATA_W-1:0] wdata_reg;  // write data latched at grant
   logic [CW-1:0]     iss_cnt;    // reads issued so far in this burst
   logic [CW-1:0]     ret_cnt;    // words returned so far in this burst

   logic active;
   logic ret_fire;
   logic ret_done;

   // Return qualification: memory data only counts while a fill is outstanding.
   always_comb begin
      active   = (state == ISSUE) || (state == DRAIN);
      ret_fire = active && mem_data_valid;
      ret_done = ret_fire && (ret_cnt == LAST);
   end

   // Arbitration and burst sequencing; reset aborts any operation instantly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant_d   <= 1'b0;
         last_d    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         iss_cnt   <= '0;
         ret_cnt   <= '0;
      end else begin
         if (ret_fire) begin
            ret_cnt <= ret_done ? '0 : ret_cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               iss_cnt <= '0;
               ret_cnt <= '0;
               // On a tie the side that did not win last time is served.
               if (d_req && (!i_req || !last_d)) begin
                  grant_d   <= 1'b1;
                  last_d    <= 1'b1;
                  addr_reg  <= d_addr;
                  wdata_reg <= d_wdata;
                  state     <= d_wr ? WRITE : ISSUE;
               end else if (i_req) begin
                  grant_d  <= 1'b0;
                  last_d   <= 1'b0;
                  addr_reg <= i_addr;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               iss_cnt <= iss_cnt + 1'b1;
               if (iss_cnt == LAST) begin
                  state <= ret_done ? IDLE : DRAIN;
               end
            end
            DRAIN: begin
               if (ret_done) begin
                  state <= IDLE;
               end
            end
            WRITE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output decode from registered state; returns are steered in the cycle they arrive.
   always_comb begin
      i_busy       = (state != IDLE) && !grant_d;
      d_busy       = (state != IDLE) && grant_d;
      i_data_valid = ret_fire && !grant_d;
      d_data_valid = ret_fire && grant_d;
      i_word       = (ret_fire && !grant_d) ? ret_cnt : '0;
      d_word       = (ret_fire && grant_d) ? ret_cnt : '0;
      i_done       = ret_done && !grant_d;
      d_done       = (ret_done && grant_d) || (state == WRITE);
      rd_data      = ret_fire ? mem_data_out : '0;
      mem_enable   = (state == ISSUE) || (state == WRITE);
      mem_wr       = (state == WRITE);
      mem_addr     = '0;
      mem_data_in  = '0;
      if (state == ISSUE) begin
         mem_addr = (addr_reg & BLOCK_MASK) + (ADDR_W'(iss_cnt) << 1);
      end else if (state == WRITE) begin
         mem_addr    = addr_reg;
         mem_data_in = wdata_reg;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios against a fixed-latency memory model.
module tb_mem_arbiter;

   localparam int BURST = 8;
   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int LAT   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, d_req, d_wr;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          i_busy, i_data_valid, i_done;
   logic          d_busy, d_data_valid, d_done;
   logic [2:0]    i_word, d_word;
   logic [DW-1:0] rd_data, mem_data_in, mem_data_out;
   logic [AW-1:0] mem_addr;
   logic          mem_enable, mem_wr, mem_data_valid;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   mem_arbiter #(.BURST(BURST), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_busy(i_busy), .i_data_valid(i_data_valid),
      .i_word(i_word), .i_done(i_done),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_busy(d_busy),
      .d_data_valid(d_data_valid), .d_word(d_word), .d_done(d_done),
      .rd_data(rd_data), .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: reads return addr ^ 0x5A5A exactly LAT cycles after issue.
   logic [LAT-1:0]         vp = '0;
   logic [LAT-1:0][DW-1:0] dp = '0;
   logic                   stray = 1'b0;
   logic [DW-1:0]          stray_data = '0;
   always @(posedge clk) begin
      vp <= {vp[LAT-2:0], mem_enable && !mem_wr};
      dp <= {dp[LAT-2:0], mem_addr ^ 16'h5A5A};
   end
   assign mem_data_valid = vp[LAT-1] | stray;
   assign mem_data_out   = stray ? stray_data : dp[LAT-1];

   // Activity logs collected at every falling edge.
   typedef struct {logic [AW-1:0] addr; int cyc;} iss_t;
   typedef struct {logic d; logic [2:0] word; logic [DW-1:0] data; logic done; int cyc;} ret_t;
   typedef struct {logic d; int cyc;} done_t;
   iss_t  iss_q[$];
   ret_t  ret_q[$];
   done_t done_q[$];
   int    wr_n = 0, busy_i_n = 0, busy_d_n = 0;

   always @(negedge clk) begin
      iss_t  ie;
      ret_t  re;
      done_t de;
      if (mem_enable && !mem_wr) begin
         ie.addr = mem_addr; ie.cyc = cyc; iss_q.push_back(ie);
      end
      if (mem_enable && mem_wr) wr_n++;
      if (i_data_valid) begin
         re.d = 1'b0; re.word = i_word; re.data = rd_data; re.done = i_done; re.cyc = cyc;
         ret_q.push_back(re);
      end
      if (d_data_valid) begin
         re.d = 1'b1; re.word = d_word; re.data = rd_data; re.done = d_done; re.cyc = cyc;
         ret_q.push_back(re);
      end
      if (i_done) begin
         de.d = 1'b0; de.cyc = cyc; done_q.push_back(de);
         $display("txn: I-cache fill done at cycle %0d", cyc);
      end
      if (d_done) begin
         de.d = 1'b1; de.cyc = cyc; done_q.push_back(de);
         $display("txn: D-cache %s done at cycle %0d", mem_wr ? "write" : "fill", cyc);
      end
      if (i_busy) busy_i_n++;
      if (d_busy) busy_d_n++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      iss_q.delete();
      ret_q.delete();
      done_q.delete();
      wr_n = 0; busy_i_n = 0; busy_d_n = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [63:0] outs;
      rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
      tick();
      outs = {i_busy, i_data_valid, i_word, i_done, d_busy, d_data_valid, d_word, d_done,
              rd_data, mem_addr, mem_enable, mem_wr, mem_data_in};
      n_cmp++; if (outs !== 64'h0) begin n_bad++; $display("FAIL reset_outputs got=%0h want=0", outs); end
      rst = 1'b0;
      tick();
      tick();
      n_cmp++; if (mem_enable !== 1'b0) begin n_bad++; $display("FAIL idle_mem_enable got=%0b want=0", mem_enable); end
   endtask

   task automatic test_i_read();
      int req_cyc, got;
      clear_logs();
      i_req = 1; i_addr = 16'h1234;
      req_cyc = cyc;
      got = 0;
      for (int t = 0; t < 40; t++) begin
         tick();
         if (i_done) begin got = 1; break; end
      end
      i_req = 0;
      n_cmp++; if (got !== 1) begin n_bad++; $display("FAIL i_read_timeout got=%0d want=1", got); end
      repeat (3) tick();
      n_cmp++; if (iss_q.size() !== 8) begin n_bad++; $display("FAIL i_read_issue_count got=%0d want=8", iss_q.size()); end
      n_cmp++; if (ret_q.size() !== 8) begin n_bad++; $display("FAIL i_read_return_count got=%0d want=8", ret_q.size()); end
      if (iss_q.size() == 8 && ret_q.size() == 8) begin
         for (int k = 0; k < 8; k++) begin
            logic [AW-1:0] ea;
            ea = 16'h1230 + 16'(2 * k);
            n_cmp++; if (iss_q[k].addr !== ea) begin n_bad++; $display("FAIL i_read_addr[%0d] got=%0h want=%0h", k, iss_q[k].addr, ea); end
            n_cmp++; if (iss_q[k].cyc !== req_cyc + 1 + k) begin n_bad++; $display("FAIL i_read_issue_cyc[%0d] got=%0d want=%0d", k, iss_q[k].cyc, req_cyc + 1 + k); end
            n_cmp++; if (ret_q[k].word !== 3'(k)) begin n_bad++; $display("FAIL i_read_word[%0d] got=%0d want=%0d", k, ret_q[k].word, k); end
            n_cmp++; if (ret_q[k].data !== (ea ^ 16'h5A5A)) begin n_bad++; $display("FAIL i_read_data[%0d] got=%0h want=%0h", k, ret_q[k].data, ea ^ 16'h5A5A); end
            n_cmp++; if (ret_q[k].d !== 1'b0) begin n_bad++; $display("FAIL i_read_side[%0d] got=%0b want=0", k, ret_q[k].d); end
            n_cmp++; if (ret_q[k].done !== (k == 7)) begin n_bad++; $display("FAIL i_read_done_flag[%0d] got=%0b want=%0b", k, ret_q[k].done, k == 7); end
         end
         n_cmp++; if (ret_q[0].cyc - iss_q[0].cyc !== LAT) begin n_bad++; $display("FAIL i_read_latency got=%0d want=%0d", ret_q[0].cyc - iss_q[0].cyc, LAT); end
      end
      n_cmp++; if (done_q.size() !== 1) begin n_bad++; $display("FAIL i_read_done_count got=%0d want=1", done_q.size()); end
      if (done_q.size() == 1) begin
         n_cmp++; if (done_q[0].cyc !== req_cyc + 1 + LAT + BURST - 1) begin n_bad++; $display("FAIL i_read_done_cyc got=%0d want=%0d", done_q[0].cyc, req_cyc + 1 + LAT + BURST - 1); end
      end
      n_cmp++; if (busy_i_n !== LAT + BURST) begin n_bad++; $display("FAIL i_busy_cycles got=%0d want=%0d", busy_i_n, LAT + BURST); end
      n_cmp++; if (busy_d_n !== 0) begin n_bad++; $display("FAIL d_busy_cycles got=%0d want=0", busy_d_n); end
   endtask

   task automatic test_tie();
      do_reset();
      clear_logs();
      i_req = 1; i_addr = 16'h300A; d_req = 1; d_wr = 0; d_addr = 16'h2006;
      for (int t = 0; t < 80; t++) begin
         tick();
         if (d_done) d_req = 0;
         if (i_done) begin i_req = 0; break; end
      end
      i_req = 0; d_req = 0;
      repeat (3) tick();
      n_cmp++; if (done_q.size() !== 2) begin n_bad++; $display("FAIL tie_done_count got=%0d want=2", done_q.size()); end
      if (done_q.size() == 2 && iss_q.size() == 16) begin
         n_cmp++; if (done_q[0].d !== 1'b1) begin n_bad++; $display("FAIL tie_first_side got=%0b want=1", done_q[0].d); end
         n_cmp++; if (done_q[1].d !== 1'b0) begin n_bad++; $display("FAIL tie_second_side got=%0b want=0", done_q[1].d); end
         n_cmp++; if (iss_q[0].addr !== 16'h2000) begin n_bad++; $display("FAIL tie_d_base got=%0h want=2000", iss_q[0].addr); end
         n_cmp++; if (iss_q[8].addr !== 16'h3000) begin n_bad++; $display("FAIL tie_i_base got=%0h want=3000", iss_q[8].addr); end
         n_cmp++; if (iss_q[8].cyc !== done_q[0].cyc + 2) begin n_bad++; $display("FAIL tie_idle_gap got=%0d want=%0d", iss_q[8].cyc, done_q[0].cyc + 2); end
      end else begin
         n_cmp++; n_bad++; $display("FAIL tie_issue_count got=%0d want=16", iss_q.size());
      end
   endtask

   task automatic test_alternate();
      int dn;
      clear_logs();
      dn = 0;
      i_req = 1; i_addr = 16'h7000; d_req = 1; d_wr = 0; d_addr = 16'h6000;
      for (int t = 0; t < 200; t++) begin
         tick();
         if (i_done || d_done) dn++;
         if (dn == 4) break;
      end
      i_req = 0; d_req = 0;
      repeat (3) tick();
      n_cmp++; if (done_q.size() !== 4) begin n_bad++; $display("FAIL alt_done_count got=%0d want=4", done_q.size()); end
      if (done_q.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            n_cmp++; if (done_q[k].d !== ((k % 2) == 0)) begin n_bad++; $display("FAIL alt_side[%0d] got=%0b want=%0b", k, done_q[k].d, (k % 2) == 0); end
         end
      end
      if (ret_q.size() == 32) begin
         n_cmp++; if (ret_q[8].word !== 3'd0) begin n_bad++; $display("FAIL alt_word_wrap got=%0d want=0", ret_q[8].word); end
         n_cmp++; if (ret_q[8].data !== (16'h7000 ^ 16'h5A5A)) begin n_bad++; $display("FAIL alt_i_data got=%0h want=%0h", ret_q[8].data, 16'h7000 ^ 16'h5A5A); end
      end else begin
         n_cmp++; n_bad++; $display("FAIL alt_return_count got=%0d want=32", ret_q.size());
      end
   endtask

   task automatic test_write();
      int req_cyc, got;
      clear_logs();
      d_req = 1; d_wr = 1; d_addr = 16'h0042; d_wdata = 16'hBEEF;
      req_cyc = cyc;
      got = 0;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (d_done) begin got = 1; break; end
      end
      n_cmp++; if (got !== 1) begin n_bad++; $display("FAIL write_timeout got=%0d want=1", got); end
      n_cmp++; if (cyc !== req_cyc + 1) begin n_bad++; $display("FAIL write_cyc got=%0d want=%0d", cyc, req_cyc + 1); end
      n_cmp++; if ({mem_enable, mem_wr} !== 2'b11) begin n_bad++; $display("FAIL write_strobes got=%0b want=11", {mem_enable, mem_wr}); end
      n_cmp++; if (mem_addr !== 16'h0042) begin n_bad++; $display("FAIL write_addr got=%0h want=0042", mem_addr); end
      n_cmp++; if (mem_data_in !== 16'hBEEF) begin n_bad++; $display("FAIL write_data got=%0h want=beef", mem_data_in); end
      n_cmp++; if ({d_busy, d_data_valid} !== 2'b10) begin n_bad++; $display("FAIL write_busy_valid got=%0b want=10", {d_busy, d_data_valid}); end
      d_req = 0; d_wr = 0;
      tick();
      n_cmp++; if ({mem_enable, mem_wr, mem_addr, mem_data_in} !== 34'h0) begin n_bad++; $display("FAIL write_after got=%0h want=0", {mem_enable, mem_wr, mem_addr, mem_data_in}); end
      repeat (6) tick();
      n_cmp++; if (wr_n !== 1 || iss_q.size() !== 0 || ret_q.size() !== 0) begin n_bad++; $display("FAIL write_single got=%0d/%0d/%0d want=1/0/0", wr_n, iss_q.size(), ret_q.size()); end
   endtask

   task automatic test_rst_mid();
      logic [63:0] outs;
      int got;
      clear_logs();
      i_req = 1; i_addr = 16'h4000;
      got = 0;
      for (int t = 0; t < 40; t++) begin
         tick();
         if (ret_q.size() >= 3) begin got = 1; break; end
      end
      n_cmp++; if (got !== 1) begin n_bad++; $display("FAIL rst_mid_timeout got=%0d want=1", got); end
      rst = 1'b1;
      #1;
      outs = {i_busy, i_data_valid, i_word, i_done, d_busy, d_data_valid, d_word, d_done,
              rd_data, mem_addr, mem_enable, mem_wr, mem_data_in};
      n_cmp++; if (outs !== 64'h0) begin n_bad++; $display("FAIL rst_mid_outputs got=%0h want=0", outs); end
      i_req = 0;
      tick();
      tick();
      rst = 1'b0;
      clear_logs();
      repeat (10) tick();
      n_cmp++; if (ret_q.size() !== 0 || done_q.size() !== 0) begin n_bad++; $display("FAIL rst_late_returns got=%0d/%0d want=0/0", ret_q.size(), done_q.size()); end
      // A fresh fill after reset must start from word 0.
      d_req = 1; d_wr = 0; d_addr = 16'h5000;
      for (int t = 0; t < 40; t++) begin
         tick();
         if (d_done) break;
      end
      d_req = 0;
      repeat (3) tick();
      n_cmp++; if (ret_q.size() !== 8) begin n_bad++; $display("FAIL rst_refill_count got=%0d want=8", ret_q.size()); end
      if (ret_q.size() == 8) begin
         n_cmp++; if (ret_q[0].word !== 3'd0 || ret_q[0].d !== 1'b1) begin n_bad++; $display("FAIL rst_refill_first got=%0d/%0b want=0/1", ret_q[0].word, ret_q[0].d); end
         n_cmp++; if (ret_q[7].done !== 1'b1) begin n_bad++; $display("FAIL rst_refill_done got=%0b want=1", ret_q[7].done); end
      end
   endtask

   task automatic test_stray();
      clear_logs();
      tick();
      stray = 1'b1; stray_data = 16'h1111;
      #1;
      n_cmp++; if ({i_data_valid, d_data_valid, i_done, d_done} !== 4'b0) begin n_bad++; $display("FAIL stray_flags got=%0b want=0", {i_data_valid, d_data_valid, i_done, d_done}); end
      n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL stray_rd_data got=%0h want=0", rd_data); end
      tick();
      stray = 1'b0;
      i_req = 1; i_addr = 16'h0010;
      for (int t = 0; t < 40; t++) begin
         tick();
         if (i_done) break;
      end
      i_req = 0;
      repeat (3) tick();
      n_cmp++; if (ret_q.size() !== 8) begin n_bad++; $display("FAIL stray_fill_count got=%0d want=8", ret_q.size()); end
      if (ret_q.size() == 8) begin
         n_cmp++; if (ret_q[0].word !== 3'd0) begin n_bad++; $display("FAIL stray_first_word got=%0d want=0", ret_q[0].word); end
         n_cmp++; if (ret_q[0].data !== (16'h0010 ^ 16'h5A5A)) begin n_bad++; $display("FAIL stray_first_data got=%0h want=%0h", ret_q[0].data, 16'h0010 ^ 16'h5A5A); end
         n_cmp++; if (ret_q[7].done !== 1'b1 || ret_q[6].done !== 1'b0) begin n_bad++; $display("FAIL stray_done_pos got=%0b%0b want=01", ret_q[6].done, ret_q[7].done); end
      end
   endtask

   initial begin
      test_reset();
      test_i_read();
      test_tie();
      test_alternate();
      test_write();
      test_rst_mid();
      test_stray();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
